// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock FIFO with thresholds, FWFT/registered read and sticky error flags
module fifo_sync #(
   parameter int WIDTH     = 27,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter bit FWFT      = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [WIDTH-1:0]             data_in,
   input  logic                         write_valid,
   input  logic                         read_valid,
   output logic [WIDTH-1:0]             data_out,
   output logic                         data_out_valid,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp_q, rp_q;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, empty_q, afull_q, aempty_q;
   logic             overflow_q, underflow_q;
   logic             wr_ok, rd_ok;

   // A pop frees a slot in the same edge, so a write into a full FIFO is accepted alongside it.
   assign rd_ok = read_valid & ~empty_q;
   assign wr_ok = write_valid & (~full_q | rd_ok);

   always_comb begin
      count_d = count_q;
      if (wr_ok && !rd_ok) begin
         count_d = count_q + CW'(1);
      end else if (!wr_ok && rd_ok) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wp_q        <= '0;
         rp_q        <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         afull_q     <= 1'b0;
         aempty_q    <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_ok) wp_q <= wp_q + AW'(1);
         if (rd_ok) rp_q <= rp_q + AW'(1);
         count_q  <= count_d;
         full_q   <= (count_d == DEPTH_C);
         empty_q  <= (count_d == '0);
         afull_q  <= (count_d >= AF_C);
         aempty_q <= (count_d <= AE_C);
         if (write_valid && full_q && !rd_ok) overflow_q  <= 1'b1;
         if (read_valid && empty_q)           underflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && wr_ok) mem[wp_q] <= data_in;
   end

   generate
      if (FWFT) begin : g_fwft
         // Remembers the last word shown so data_out holds steady once the FIFO drains.
         logic [WIDTH-1:0] hold_q;
         always_ff @(posedge clk) begin
            if (!rst) begin
               hold_q <= '0;
            end else if (rd_ok) begin
               hold_q <= mem[rp_q];
            end
         end
         assign data_out       = empty_q ? hold_q : mem[rp_q];
         assign data_out_valid = ~empty_q;
      end else begin : g_reg
         logic [WIDTH-1:0] dout_q;
         logic             dvalid_q;
         always_ff @(posedge clk) begin
            if (!rst) begin
               dout_q   <= '0;
               dvalid_q <= 1'b0;
            end else begin
               dvalid_q <= rd_ok;
               if (rd_ok) dout_q <= mem[rp_q];
            end
         end
         assign data_out       = dout_q;
         assign data_out_valid = dvalid_q;
      end
   endgenerate

   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule
